// File: rtl/kf_pkg.sv
// kf_pkg -- shared definitions for the host loader slice.
//   KF_W, KF_ADDRW : default data word and register-file address widths.
//   hl_state_t     : host_loader FSM state encoding (LOAD, ARM, BUSY).
//   cnt_width()    : bits needed to hold a count in the range 0..n.
package kf_pkg;

  localparam int KF_W     = 24;
  localparam int KF_ADDRW = 5;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ARM  = 2'd1,
    ST_BUSY = 2'd2
  } hl_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hl_fifo.sv
// hl_fifo -- small synchronous FIFO buffering host words for host_loader.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   push/wdata : write request and word; ignored when the FIFO is full
//   pop        : read request; ignored when the FIFO is empty
//   rdata      : word at the head of the FIFO (combinational from storage)
//   empty      : no words stored
//   count      : registered number of stored words, 0..DEPTH
// Storage itself is not reset; only pointers and count are.
module hl_fifo
  import kf_pkg::*;
#(
  parameter int WIDTH = KF_W + KF_ADDRW,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps the pointers correct even if DEPTH is not a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/host_loader.sv
// host_loader -- feeds host measurement words into the filter core's router A
// and kicks off one filter iteration every LOAD_CNT words.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   host_valid/host_data/host_addr : host word offer (accepted when host_ready)
//   host_ready           : FIFO has room (from registered count only)
//   DATA_IN, DIR         : popped word and register address, held between writes
//   WRITE                : one-cycle write strobe, the cycle after a pop
//   READY                : core can take a write this cycle
//   DONE                 : core finished the current iteration (honoured in BUSY)
//   START                : one-cycle iteration-start pulse
// Flow: LOAD pops words while READY; the LOAD_CNT-th pop moves to ARM, ARM
// emits START and enters BUSY, DONE in BUSY returns to LOAD. Host pushes are
// accepted in every state so the next iteration's words can be prefetched.
module host_loader
  import kf_pkg::*;
#(
  parameter int W        = KF_W,
  parameter int ADDRW    = KF_ADDRW,
  parameter int DEPTH    = 4,
  parameter int LOAD_CNT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_valid,
  input  logic [W-1:0]     host_data,
  input  logic [ADDRW-1:0] host_addr,
  output logic             host_ready,
  output logic [W-1:0]     DATA_IN,
  output logic [ADDRW-1:0] DIR,
  output logic             WRITE,
  input  logic             READY,
  input  logic             DONE,
  output logic             START
);

  localparam int FW = W + ADDRW;
  localparam int CW = cnt_width(DEPTH);
  // LOAD_CNT may equal 2^ADDRW, so the issue counter needs one extra bit.
  localparam int IW = ADDRW + 1;
  localparam logic [IW-1:0] LAST_ISSUE = IW'(LOAD_CNT);

  logic            push;
  logic [FW-1:0]   fifo_rdata;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  hl_state_t       state;
  hl_state_t       state_next;
  logic [IW-1:0]   issue_cnt;
  logic [IW-1:0]   issue_next;
  logic            pop_p0;
  logic            start_p0;

  assign host_ready = (fifo_count < CW'(DEPTH));
  assign push       = host_valid && host_ready;

  hl_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({host_addr, host_data}),
    .pop   (pop_p0),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stage p0: pop decision and next-state logic from registered state.
  always_comb begin
    state_next = state;
    issue_next = issue_cnt;
    pop_p0     = 1'b0;
    start_p0   = 1'b0;
    case (state)
      ST_LOAD: begin
        if (!fifo_empty && READY) begin
          pop_p0     = 1'b1;
          issue_next = issue_cnt + 1'b1;
          if (issue_cnt + 1'b1 == LAST_ISSUE) begin
            state_next = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        start_p0   = 1'b1;
        state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (DONE) begin
          state_next = ST_LOAD;
          issue_next = '0;
        end
      end
      default: begin
        state_next = ST_LOAD;
        issue_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      issue_cnt <= '0;
    end else begin
      state     <= state_next;
      issue_cnt <= issue_next;
    end
  end

  // Stage p1: registered outputs; DATA_IN/DIR only change on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WRITE   <= 1'b0;
      START   <= 1'b0;
      DATA_IN <= '0;
      DIR     <= '0;
    end else begin
      WRITE <= pop_p0;
      START <= start_p0;
      if (pop_p0) begin
        DATA_IN <= fifo_rdata[W-1:0];
        DIR     <= fifo_rdata[FW-1:W];
      end
    end
  end

endmodule

// File: tb/tb_host_loader.sv
// tb_host_loader -- directed, table-driven bench for host_loader plus
// hand-written sequences for the prefetch, READY-toggle and mid-iteration
// reset cases.
`timescale 1ns/1ps
module tb_host_loader;

  localparam int W        = 24;
  localparam int ADDRW    = 5;
  localparam int DEPTH    = 4;
  localparam int LOAD_CNT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             host_valid = 1'b0;
  logic [W-1:0]     host_data = '0;
  logic [ADDRW-1:0] host_addr = '0;
  logic             host_ready;
  logic [W-1:0]     DATA_IN;
  logic [ADDRW-1:0] DIR;
  logic             WRITE;
  logic             READY = 1'b0;
  logic             DONE = 1'b0;
  logic             START;

  always #5 clk = ~clk;

  host_loader #(
    .W        (W),
    .ADDRW    (ADDRW),
    .DEPTH    (DEPTH),
    .LOAD_CNT (LOAD_CNT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_addr  (host_addr),
    .host_ready (host_ready),
    .DATA_IN    (DATA_IN),
    .DIR        (DIR),
    .WRITE      (WRITE),
    .READY      (READY),
    .DONE       (DONE),
    .START      (START)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit               rs;   // reset before this row
    logic             v;
    logic [W-1:0]     d;
    logic [ADDRW-1:0] a;
    logic             r;
    logic             dn;
    logic             hr;   // expected outputs during this cycle
    logic             wr;
    logic [W-1:0]     din;
    logic [ADDRW-1:0] dir;
    logic             st;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    host_valid = 1'b0;
    host_data  = '0;
    host_addr  = '0;
    READY      = 1'b0;
    DONE       = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("reset WRITE", 32'(WRITE), 0);
    chk("reset START", 32'(START), 0);
    chk("reset DATA_IN", 32'(DATA_IN), 0);
    chk("reset DIR", 32'(DIR), 0);
    chk("reset host_ready", 32'(host_ready), 1);
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic void add(bit rs, logic v, logic [W-1:0] d, logic [ADDRW-1:0] a,
                              logic r, logic dn, logic hr, logic wr,
                              logic [W-1:0] din, logic [ADDRW-1:0] dir, logic st);
    vec_t e;
    e = '{rs, v, d, a, r, dn, hr, wr, din, dir, st};
    tab.push_back(e);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+ADDRW-1:0] q[$];
    logic [W+ADDRW-1:0] exp_w;
    bit   seen;
    bit   acc;
    logic rdy_prev;
    int   sent;
    int   got;
    int   nwr;
    bit   st_seen;

    // Table A: back-to-back load of three words, DONE ignored in LOAD/ARM,
    // DONE accepted in the START cycle, then a fresh iteration begins.
    //   rs v  data         addr  R  D  | hr W  DATA_IN      DIR   S
    add(1, 1, 24'h000111, 5'd1, 1, 0,   1, 0, 24'h000000, 5'd0, 0);
    add(0, 1, 24'h000222, 5'd2, 1, 1,   1, 0, 24'h000000, 5'd0, 0);
    add(0, 1, 24'h000333, 5'd3, 1, 0,   1, 1, 24'h000111, 5'd1, 0);
    add(0, 0, 24'h000000, 5'd0, 1, 0,   1, 1, 24'h000222, 5'd2, 0);
    add(0, 0, 24'h000000, 5'd0, 1, 1,   1, 1, 24'h000333, 5'd3, 0);
    add(0, 0, 24'h000000, 5'd0, 1, 1,   1, 0, 24'h000333, 5'd3, 1);
    add(0, 1, 24'h000444, 5'd4, 1, 0,   1, 0, 24'h000333, 5'd3, 0);
    add(0, 0, 24'h000000, 5'd0, 1, 0,   1, 0, 24'h000333, 5'd3, 0);
    add(0, 0, 24'h000000, 5'd0, 1, 0,   1, 1, 24'h000444, 5'd4, 0);
    add(0, 0, 24'h000000, 5'd0, 1, 0,   1, 0, 24'h000444, 5'd4, 0);
    // Table B: five pushes with READY=0 fill the FIFO, the fifth is held
    // until the cycle after the first pop.
    add(1, 1, 24'h00A001, 5'h10, 0, 0,  1, 0, 24'h000000, 5'h00, 0);
    add(0, 1, 24'h00A002, 5'h11, 0, 0,  1, 0, 24'h000000, 5'h00, 0);
    add(0, 1, 24'h00A003, 5'h12, 0, 0,  1, 0, 24'h000000, 5'h00, 0);
    add(0, 1, 24'h00A004, 5'h13, 0, 0,  1, 0, 24'h000000, 5'h00, 0);
    add(0, 1, 24'h00A005, 5'h14, 0, 0,  0, 0, 24'h000000, 5'h00, 0);
    add(0, 1, 24'h00A005, 5'h14, 1, 0,  0, 0, 24'h000000, 5'h00, 0);
    add(0, 1, 24'h00A005, 5'h14, 1, 0,  1, 1, 24'h00A001, 5'h10, 0);
    add(0, 0, 24'h000000, 5'h00, 1, 0,  1, 1, 24'h00A002, 5'h11, 0);
    add(0, 0, 24'h000000, 5'h00, 1, 0,  1, 1, 24'h00A003, 5'h12, 0);
    add(0, 0, 24'h000000, 5'h00, 1, 0,  1, 0, 24'h00A003, 5'h12, 1);
    add(0, 0, 24'h000000, 5'h00, 1, 0,  1, 0, 24'h00A003, 5'h12, 0);

    #2;
    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].rs) do_reset();
      host_valid = tab[i].v;
      host_data  = tab[i].d;
      host_addr  = tab[i].a;
      READY      = tab[i].r;
      DONE       = tab[i].dn;
      chk($sformatf("row%0d host_ready", i), 32'(host_ready), 32'(tab[i].hr));
      chk($sformatf("row%0d WRITE", i), 32'(WRITE), 32'(tab[i].wr));
      chk($sformatf("row%0d DATA_IN", i), 32'(DATA_IN), 32'(tab[i].din));
      chk($sformatf("row%0d DIR", i), 32'(DIR), 32'(tab[i].dir));
      chk($sformatf("row%0d START", i), 32'(START), 32'(tab[i].st));
      step();
    end
    host_valid = 1'b0;
    chk("B prefetched count", 32'(dut.u_fifo.count), 2);

    // Sequence C: prefetch two words while BUSY, DONE held low for 10 cycles.
    do_reset();
    READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_valid = 1'b1;
      host_data  = 24'h00C000 + 24'(i);
      host_addr  = 5'(i + 8);
      step();
    end
    host_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (START) seen = 1'b1;
      else step();
    end
    chk("C START seen", 32'(seen), 1);
    host_valid = 1'b1;
    host_data  = 24'h00CA00;
    host_addr  = 5'h1A;
    step();
    host_data  = 24'h00CB00;
    host_addr  = 5'h1B;
    step();
    host_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("C busy%0d WRITE", k), 32'(WRITE), 0);
      step();
    end
    chk("C fifo_count", 32'(dut.u_fifo.count), 2);
    DONE = 1'b1;
    step();
    DONE = 1'b0;
    chk("C u+1 WRITE", 32'(WRITE), 0);
    step();
    chk("C u+2 WRITE", 32'(WRITE), 1);
    chk("C u+2 DATA_IN", 32'(DATA_IN), 32'h00CA00);
    chk("C u+2 DIR", 32'(DIR), 32'h1A);
    step();
    chk("C u+3 WRITE", 32'(WRITE), 1);
    chk("C u+3 DATA_IN", 32'(DATA_IN), 32'h00CB00);
    chk("C u+3 DIR", 32'(DIR), 32'h1B);

    // Sequence D: 12 words through a full FIFO with READY toggling 1,0,1,0.
    do_reset();
    q.delete();
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 300 && got < 12; cyc++) begin
      host_valid = (sent < 12);
      host_data  = 24'h00D000 + 24'(sent);
      host_addr  = 5'(sent + 3);
      READY      = (cyc >= 6) && (cyc % 2 == 0);
      DONE       = START;
      acc        = host_valid && host_ready;
      rdy_prev   = READY;
      step();
      if (acc) begin
        q.push_back({host_addr, host_data});
        sent++;
      end
      if (WRITE) begin
        chk("D READY before WRITE", 32'(rdy_prev), 1);
        if (q.size() == 0) begin
          chk("D spurious WRITE", 32'(WRITE), 0);
        end else begin
          exp_w = q.pop_front();
          chk("D DATA_IN", 32'(DATA_IN), 32'(exp_w[W-1:0]));
          chk("D DIR", 32'(DIR), 32'(exp_w[W+ADDRW-1:W]));
        end
        got++;
      end
    end
    host_valid = 1'b0;
    READY = 1'b0;
    DONE  = 1'b0;
    chk("D words written", 32'(got), 12);
    chk("D queue drained", 32'(q.size()), 0);

    // Sequence E: reset after the second WRITE of an iteration.
    do_reset();
    READY = 1'b1;
    nwr = 0;
    for (int i = 0; i < 3; i++) begin
      host_valid = 1'b1;
      host_data  = 24'h00E000 + 24'(i);
      host_addr  = 5'(i + 20);
      step();
      if (WRITE) nwr++;
    end
    host_valid = 1'b0;
    chk("E writes before reset", 32'(nwr), 2);
    rst_n = 1'b0;
    #1;
    chk("E async WRITE", 32'(WRITE), 0);
    chk("E async DATA_IN", 32'(DATA_IN), 0);
    chk("E async DIR", 32'(DIR), 0);
    chk("E async START", 32'(START), 0);
    chk("E async host_ready", 32'(host_ready), 1);
    chk("E async count", 32'(dut.u_fifo.count), 0);
    step();
    step();
    rst_n = 1'b1;
    st_seen = 1'b0;
    nwr = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (START) st_seen = 1'b1;
      if (WRITE) nwr++;
    end
    chk("E no START after reset", 32'(st_seen), 0);
    chk("E no WRITE after reset", 32'(nwr), 0);
    for (int i = 0; i < 2; i++) begin
      host_valid = 1'b1;
      host_data  = 24'h00E100 + 24'(i);
      host_addr  = 5'(i + 24);
      step();
      if (WRITE) nwr++;
      if (START) st_seen = 1'b1;
    end
    host_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (START) st_seen = 1'b1;
      if (WRITE) nwr++;
    end
    chk("E two words no START", 32'(st_seen), 0);
    chk("E two words written", 32'(nwr), 2);
    host_valid = 1'b1;
    host_data  = 24'h00E102;
    host_addr  = 5'd26;
    step();
    host_valid = 1'b0;
    for (int k = 0; k < 10 && !st_seen; k++) begin
      if (WRITE) nwr++;
      if (START) st_seen = 1'b1;
      else step();
    end
    chk("E START after full load", 32'(st_seen), 1);
    chk("E writes before START", 32'(nwr), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
